// File: rtl/lid_pkg.sv
// Shared definitions for the credit-based latency-insensitive channel.
// Used by the sender and the receiver-side wrappers.
package lid_pkg;

  localparam int unsigned LID_FIFO_ADDR = 2;

  function automatic int unsigned credit_width(input int unsigned fifo_addr);
    return fifo_addr + 1;
  endfunction

  // Credit count for the default receiver FIFO size
  typedef logic [LID_FIFO_ADDR:0] credit_t;

endpackage

// File: rtl/lid_skid_buffer.sv
// Two-entry in-order register buffer between the producer handshake and the send stage.
// Entry 0 is always the head; not_full_o is registered from the next occupancy.
module lid_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         not_full_o,
  output logic                         not_empty_c
);

  logic signed [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic signed [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic [1:0]                   wr_pos;
  logic                         not_full_q, not_full_d;

  // A pop shifts entry 1 forward; a push then lands behind the surviving entries
  always_comb begin
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    wr_pos     = cnt_q;
    if (pop_i) begin
      ent0_d = ent1_q;
      wr_pos = cnt_q - 2'd1;
    end
    if (push_i) begin
      if (wr_pos == 2'd0) ent0_d = data_i;
      else                ent1_d = data_i;
    end
    cnt_d      = cnt_q + 2'(push_i) - 2'(pop_i);
    not_full_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent0_q     <= '0;
      ent1_q     <= '0;
      cnt_q      <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
      not_full_q <= not_full_d;
    end
  end

  assign data_o      = ent0_q;
  assign not_full_o  = not_full_q;
  assign not_empty_c = (cnt_q != 2'd0);

endmodule

// File: rtl/credit_sender.sv
// Upstream end of the credit-based channel: buffers producer words and issues
// registered enqueue pulses to the receiver FIFO only while credits remain.
module credit_sender
  import lid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_ADDR  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_enq,
  input  logic                         i_credit,
  output logic [FIFO_ADDR:0]           o_credits,
  output logic                         o_credit_err
);

  localparam int unsigned CW    = credit_width(FIFO_ADDR);
  localparam int unsigned DEPTH = 1 << FIFO_ADDR;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic                         push_c, send_c, not_empty_c;
  logic signed [DATA_WIDTH-1:0] head_c;
  logic [CW-1:0]                cred_q, cred_d;
  logic                         err_q, err_d;
  logic                         enq_q, enq_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;

  lid_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push_c),
    .pop_i       (send_c),
    .data_i      (i_data),
    .data_o      (head_c),
    .not_full_o  (o_ready),
    .not_empty_c (not_empty_c)
  );

  assign push_c = i_valid && o_ready;
  // Send decision uses only the registered count: a returned credit is usable next cycle
  assign send_c = not_empty_c && (cred_q != '0);

  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    enq_d  = send_c;
    data_d = send_c ? head_c : data_q;
    case ({send_c, i_credit})
      2'b10: cred_d = cred_q - CW'(1);
      2'b01: begin
        if (cred_q == DEPTH_C) err_d  = 1'b1;
        else                   cred_d = cred_q + CW'(1);
      end
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cred_q <= DEPTH_C;
      err_q  <= 1'b0;
      enq_q  <= 1'b0;
      data_q <= '0;
    end else begin
      cred_q <= cred_d;
      err_q  <= err_d;
      enq_q  <= enq_d;
      data_q <= data_d;
    end
  end

  assign o_credits    = cred_q;
  assign o_credit_err = err_q;
  assign o_enq        = enq_q;
  assign o_data       = data_q;

endmodule

// File: doc/credit_sender.md
Name: credit_sender

Overview:
- Upstream stage of the credit-based latency-insensitive channel; drives the enqueue side of the receiver's `fifo` block.
- Accepts data from the producer over a valid/ready handshake and buffers it in a 2-entry skid buffer.
- Forwards each word as a registered enqueue pulse, but only while it holds a credit.
- Credits start at the receiver FIFO depth and come back as one pulse per receiver dequeue. The receiver FIFO therefore never overflows, and its full flag is never consulted.

Parameters:
- DATA_WIDTH, 16, width of the data word (signed); must match the receiver FIFO.
- FIFO_ADDR, 2, address width of the receiver FIFO; credit depth DEPTH = 2**FIFO_ADDR.

Ports:
- clock  input  1  single system clock.
- reset  input  1  asynchronous, active-high reset.
- i_data  input  DATA_WIDTH (signed)  producer data.
- i_valid  input  1  producer data valid.
- o_ready  output  1  sender can accept a word this cycle; registered.
- o_data  output  DATA_WIDTH (signed)  data to the receiver FIFO i_data; registered.
- o_enq  output  1  one-cycle enqueue pulse to the receiver FIFO i_enq; registered.
- i_credit  input  1  credit return, one pulse per receiver i_deq.
- o_credits  output  FIFO_ADDR+1  current credit count (debug/status).
- o_credit_err  output  1  sticky flag: credit returned while count already at DEPTH.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - o_enq=0, o_data=0, o_ready=1, o_credits=DEPTH, o_credit_err=0.
  - Skid buffer empty.
  - A reset mid-transfer discards all buffered words; in-flight credits are lost. Receiver and sender share the reset, so the FIFO is cleared too.
- Accept:
  - A word is taken on a rising edge where i_valid && o_ready.
  - Words are stored in order in the 2-entry skid buffer.
  - o_ready is registered: it deasserts the cycle after the buffer becomes full (count 2). It reasserts the cycle after the buffer drops below 2.
- Send:
  - In any cycle with buffer non-empty and credits>0, the head is popped.
  - On the next edge: o_enq<=1 and o_data<=head. Otherwise o_enq<=0 and o_data holds its value.
  - At most one send per cycle.
  - Latency: a word accepted at edge N appears with o_enq=1 in the cycle after edge N+1, i.e. 2 cycles accept-to-enq.
  - The buffer supports a simultaneous push and pop in the same cycle; ordering is preserved.
- Credit counter (FIFO_ADDR+1 bits):
  - send only: -1.
  - i_credit only: +1.
  - Both in the same cycle: unchanged.
  - Count 0: no send. The word stays at the head; o_enq=0 until a credit arrives. A credit arriving in cycle K allows a send decision in cycle K+1, so there is no combinational credit bypass.
  - i_credit while count==DEPTH and no send: count saturates at DEPTH and o_credit_err<=1. o_credit_err stays set until reset.
- Throughput: sustains one word per cycle when credits never reach 0. Credit round trip longer than DEPTH cycles throttles throughput.
- Empty buffer with credits available: o_enq=0 and no credit change.

Decomposition:
- Package lid_pkg:
  - localparam function credit_width(FIFO_ADDR)=FIFO_ADDR+1.
  - typedef for the credit count.
  - Shared by sender and future receiver-side wrappers.
- Sub-module lid_skid_buffer (DATA_WIDTH):
  - 2-entry register skid buffer.
  - Ports: push/pop, data in/out, registered not_full, and a not_empty signal.
- Credit counter, send decision and output registers live in credit_sender.

Test Plan:
- Reset: assert reset mid-stream with 2 words buffered and credits=1 -> same cycle o_enq=0, o_ready=1, o_credits=4, o_credit_err=0; buffer empty after release.
- Latency: FIFO_ADDR=2; single word 16'sh7FFF accepted at edge 1 -> o_enq=1 and o_data=0x7FFF after edge 2 only; o_credits 4->3.
- Credit exhaustion: stream 6 words with i_credit held 0 -> exactly 4 enq pulses, o_credits=0. The remaining 2 words fill the buffer and o_ready=0. Pulse i_credit once -> 1 more enq 2 cycles later, o_ready returns to 1.
- Simultaneous: credits=2, a send coincides with i_credit in the same cycle -> o_credits stays 2; data order preserved across 10 back-to-back words with a credit returned every cycle.
- Overflow error: credits=4, pulse i_credit with no send -> o_credits stays 4, o_credit_err=1 and remains 1 after further normal traffic.
- End-to-end: connect to the receiver FIFO (BRAM, FIFO_ADDR=2) with a random-deq receiver returning i_credit=i_deq; 1000 random signed words -> output sequence identical, no o_credit_err.
